lcd_spi_writer: RTL and testbench
=================================

# lcd_spi_writer

Responder to the LCD panel sequencer's two-channel request bus. It executes panel hardware-reset pulses and single-byte 4-wire SPI writes (command or data), and reports each completion with a one-cycle done pulse. It sits between the sequencer and the panel pins, and is the only block that drives the LCD RES, CS, DC, SCLK and MOSI lines.

## Interface
- CLK_DIV, 2: SCLK half-period in clk cycles, ≥1. 2 gives 12.5 MHz SCLK at 50 MHz clk.
- RST_LOW_CYC, 500_000: cycles lcd_res is held low (10 ms at 50 MHz).
- RST_WAIT_CYC, 6_000_000: cycles waited after lcd_res rises (120 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz nominal; one clock domain.
- rst  in  1  reset, synchronous, active-high.
- en_i  in  2  request pulses. Bit 0 requests a panel reset; bit 1 requests an SPI byte write.
- data_i  in  9  bit 8 = DC (0 command, 1 data); bits 7:0 = byte. Sampled only in the en_i[1] accept cycle.
- done_o  out  2  one-cycle completion pulse per channel.
- busy_o  out  1  high while any request is executing.
- lcd_res  out  1  panel reset, active-low.
- lcd_cs_n  out  1  SPI chip select.
- lcd_dc  out  1  data/command select.
- lcd_sclk  out  1  SPI clock, mode 0 (idle low, sample on rising edge).
- lcd_mosi  out  1  SPI data, MSB first.

## Operation
- States: IDLE, RST_LOW, RST_WAIT, TX_SHIFT, TX_HOLD.
- IDLE:
  - en_i[0] → RST_LOW.
  - else en_i[1] → TX_SHIFT, latching data_i.
  - en_i == 2'b11 in the same cycle: reset wins; the write is dropped and gets no done.
- en_i is accepted only in IDLE. en_i pulses in any other state are ignored, with no done and no state change.
- RST_LOW: lcd_res = 0 for RST_LOW_CYC cycles → RST_WAIT.
- RST_WAIT: lcd_res = 1 for RST_WAIT_CYC cycles → IDLE with done_o[0] = 1 for one cycle. lcd_cs_n stays high for the whole reset sequence.
- TX_SHIFT:
  - lcd_cs_n = 0 and lcd_dc = latched DC throughout.
  - For each bit, MSB first: lcd_sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - lcd_mosi updates only at the start of a low phase.
  - After 8 bits → TX_HOLD.
- TX_HOLD: lcd_sclk low and lcd_cs_n low for CLK_DIV cycles → IDLE. In that IDLE cycle, lcd_cs_n = 1 and done_o[1] = 1.
- lcd_dc and lcd_mosi keep their last values in IDLE.
- Counters: one 28-bit delay counter shared by the reset states; one bit counter (4-bit); one phase counter sized from CLK_DIV. All counters clear on every state entry.

## Timing
- Reset values: lcd_res = 1, lcd_cs_n = 1, lcd_sclk = 0, lcd_mosi = 0, lcd_dc = 0, done_o = 0, busy_o = 0, state IDLE.
- rst asserted mid-operation aborts on the next edge: outputs return to reset values, and no done is issued for the aborted request.
- Write, with en_i[1] accepted at cycle 0:
  - cycle 1: lcd_cs_n falls, lcd_dc and lcd_mosi = bit 7 valid.
  - first lcd_sclk rise at cycle 1+CLK_DIV.
  - done_o[1] and lcd_cs_n rise at cycle 1+17·CLK_DIV (cycle 35 for CLK_DIV = 2).
- Reset: en_i[0] at cycle 0 → lcd_res low for cycles 1..RST_LOW_CYC → done_o[0] at cycle 1+RST_LOW_CYC+RST_WAIT_CYC.
- busy_o is high from cycle 1 through the cycle before done; it is low in the done cycle.
- Earliest next accept: the cycle after done.
- All outputs are registered; there is no combinational path from en_i or data_i to any pin.

## Configuration
- LCD_SPI_3WIRE_EN, defined: 3-wire 9-bit mode.
  - DC is shifted as the first bit, followed by bits 7:0, for 9 SCLK periods.
  - lcd_dc is held 0.
  - done_o[1] at cycle 1+19·CLK_DIV.
- LCD_SPI_3WIRE_EN undefined: 4-wire behaviour as specified above.

## Test plan
Bench parameters: CLK_DIV=2, RST_LOW_CYC=10, RST_WAIT_CYC=20.
- Reset request: en_i=01 at cycle 0 → lcd_res low cycles 1–10, high from cycle 11; done_o=01 at cycle 31 only; lcd_cs_n stays 1 throughout.
- Command write: en_i=10, data_i=9'h036 → lcd_dc=0; MOSI sampled on the 8 SCLK rises = 0011_0110; 8 rising edges; done_o=10 at cycle 35; lcd_cs_n rises at cycle 35.
- Data write, then back-to-back: data_i=9'h1F8 → lcd_dc=1, bits 1111_1000. A second en_i[1] at cycle 20 is ignored; a new en_i[1] at cycle 36 is accepted, with lcd_cs_n falling at cycle 37.
- Collision: en_i=11 in IDLE → reset sequence only; no done_o[1]; lcd_cs_n stays 1.
- Abort: rst pulsed at cycle 12 of a write → next cycle all outputs are at reset values; no done_o; a new write afterwards completes normally.
- With LCD_SPI_3WIRE_EN: data_i=9'h12C → 9 SCLK rises carrying 1,0010_1100; lcd_dc=0; done_o[1] at cycle 39.

Source files
------------

// File: rtl/lcd_spi_writer.sv
// LCD panel pin driver: hardware-reset pulse sequencer plus single-byte SPI writer (mode 0, MSB first).
// Define LCD_SPI_3WIRE_EN for 3-wire 9-bit transfers (DC shifted first, lcd_dc held low).
module lcd_spi_writer #(
    parameter int CLK_DIV      = 2,
    parameter int RST_LOW_CYC  = 500_000,
    parameter int RST_WAIT_CYC = 6_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] en_i,
    input  logic [8:0] data_i,
    output logic [1:0] done_o,
    output logic       busy_o,
    output logic       lcd_res,
    output logic       lcd_cs_n,
    output logic       lcd_dc,
    output logic       lcd_sclk,
    output logic       lcd_mosi
);

`ifdef LCD_SPI_3WIRE_EN
    localparam int NBITS = 9;
`else
    localparam int NBITS = 8;
`endif
    localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(CLK_DIV - 1);
    localparam logic [27:0]     LOW_LAST  = 28'(RST_LOW_CYC - 1);
    localparam logic [27:0]     WAIT_LAST = 28'(RST_WAIT_CYC - 1);
    localparam logic [3:0]      BIT_LAST  = 4'(NBITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        RST_WAIT,
        TX_SHIFT,
        TX_HOLD
    } state_t;

    state_t            state;
    logic [27:0]       delay_cnt;
    logic [3:0]        bit_cnt;
    logic [PH_W-1:0]   phase_cnt;
    logic [NBITS-2:0]  remain;
    logic [NBITS-1:0]  tx_word;
    logic              tx_dc;

`ifdef LCD_SPI_3WIRE_EN
    assign tx_word = data_i;
    assign tx_dc   = 1'b0;
`else
    assign tx_word = data_i[7:0];
    assign tx_dc   = data_i[8];
`endif

    // remain holds the bits not yet placed on lcd_mosi; the MSB goes out directly at accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            delay_cnt <= '0;
            bit_cnt   <= '0;
            phase_cnt <= '0;
            remain    <= '0;
            done_o    <= 2'b00;
            busy_o    <= 1'b0;
            lcd_res   <= 1'b1;
            lcd_cs_n  <= 1'b1;
            lcd_dc    <= 1'b0;
            lcd_sclk  <= 1'b0;
            lcd_mosi  <= 1'b0;
        end else begin
            done_o <= 2'b00;
            case (state)
                IDLE: begin
                    // A done cycle is not an accept cycle; reset wins a collision.
                    if (done_o == 2'b00) begin
                        if (en_i[0]) begin
                            state     <= RST_LOW;
                            lcd_res   <= 1'b0;
                            busy_o    <= 1'b1;
                            delay_cnt <= '0;
                            bit_cnt   <= '0;
                            phase_cnt <= '0;
                        end else if (en_i[1]) begin
                            state     <= TX_SHIFT;
                            busy_o    <= 1'b1;
                            lcd_cs_n  <= 1'b0;
                            lcd_dc    <= tx_dc;
                            lcd_sclk  <= 1'b0;
                            lcd_mosi  <= tx_word[NBITS-1];
                            remain    <= tx_word[NBITS-2:0];
                            delay_cnt <= '0;
                            bit_cnt   <= '0;
                            phase_cnt <= '0;
                        end
                    end
                end

                RST_LOW: begin
                    if (delay_cnt == LOW_LAST) begin
                        state     <= RST_WAIT;
                        lcd_res   <= 1'b1;
                        delay_cnt <= '0;
                        bit_cnt   <= '0;
                        phase_cnt <= '0;
                    end else begin
                        delay_cnt <= delay_cnt + 28'd1;
                    end
                end

                RST_WAIT: begin
                    if (delay_cnt == WAIT_LAST) begin
                        state     <= IDLE;
                        done_o    <= 2'b01;
                        busy_o    <= 1'b0;
                        delay_cnt <= '0;
                        bit_cnt   <= '0;
                        phase_cnt <= '0;
                    end else begin
                        delay_cnt <= delay_cnt + 28'd1;
                    end
                end

                TX_SHIFT: begin
                    // Each half-period lasts CLK_DIV cycles; mosi moves only when a new low phase starts.
                    if (phase_cnt == PH_LAST) begin
                        phase_cnt <= '0;
                        if (!lcd_sclk) begin
                            lcd_sclk <= 1'b1;
                        end else begin
                            lcd_sclk <= 1'b0;
                            if (bit_cnt == BIT_LAST) begin
                                state     <= TX_HOLD;
                                bit_cnt   <= '0;
                                delay_cnt <= '0;
                            end else begin
                                bit_cnt  <= bit_cnt + 4'd1;
                                lcd_mosi <= remain[NBITS-2];
                                remain   <= {remain[NBITS-3:0], 1'b0};
                            end
                        end
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                TX_HOLD: begin
                    if (phase_cnt == PH_LAST) begin
                        state     <= IDLE;
                        lcd_cs_n  <= 1'b1;
                        done_o    <= 2'b10;
                        busy_o    <= 1'b0;
                        phase_cnt <= '0;
                        bit_cnt   <= '0;
                        delay_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Scoreboard bench for lcd_spi_writer: a driver pushes expected completions, a negedge monitor checks them.
module tb_lcd_spi_writer;
    localparam int D = 2;
    localparam int L = 10;
    localparam int W = 20;
`ifdef LCD_SPI_3WIRE_EN
    localparam int NB    = 9;
    localparam bit THREE = 1'b1;
`else
    localparam int NB    = 8;
    localparam bit THREE = 1'b0;
`endif

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       rst_q  = 1'b0;
    logic [1:0] en_i   = 2'b00;
    logic [8:0] data_i = 9'h000;
    logic [1:0] done_o;
    logic       busy_o, lcd_res, lcd_cs_n, lcd_dc, lcd_sclk, lcd_mosi;

    int cyc    = 0;
    int checks = 0;
    int fails  = 0;

    typedef struct {
        int         kind;
        int         acc;
        int         lat;
        logic [8:0] bits;
        logic       dc;
    } exp_t;

    exp_t sb[$];

    lcd_spi_writer #(.CLK_DIV(D), .RST_LOW_CYC(L), .RST_WAIT_CYC(W)) dut (
        .clk(clk), .rst(rst), .en_i(en_i), .data_i(data_i),
        .done_o(done_o), .busy_o(busy_o), .lcd_res(lcd_res), .lcd_cs_n(lcd_cs_n),
        .lcd_dc(lcd_dc), .lcd_sclk(lcd_sclk), .lcd_mosi(lcd_mosi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Reference model: completion code, latency and serial image of one accepted request.
    function automatic exp_t model(input logic [1:0] en, input logic [8:0] d, input int acc);
        exp_t e;
        e.acc  = acc;
        e.kind = 0;
        e.lat  = 0;
        e.bits = 9'h000;
        e.dc   = 1'b0;
        if (en[0]) begin
            e.kind = 1;
            e.lat  = 1 + L + W;
        end else if (en[1]) begin
            e.kind = 2;
            e.lat  = 1 + (2 * NB + 1) * D;
            if (THREE) begin
                e.bits = d;
                e.dc   = 1'b0;
            end else begin
                e.bits = {1'b0, d[7:0]};
                e.dc   = d[8];
            end
        end
        return e;
    endfunction

    // Monitor-side accumulators, cleared at every completion and reset.
    int         rises, cs_fall, cs_low, res_low, res_first, res_last, busy_low, dc_bad, rel;
    logic [8:0] cap;
    logic       prev_sclk;
    exp_t       cur;

    task automatic clearAcc();
        rises     = 0;
        cs_fall   = -1;
        cs_low    = 0;
        res_low   = 0;
        res_first = -1;
        res_last  = -1;
        busy_low  = 0;
        dc_bad    = 0;
        cap       = 9'h000;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_q) begin
            checkOutput("reset_values",
                        32'({lcd_res, lcd_cs_n, lcd_sclk, lcd_mosi, lcd_dc, done_o, busy_o}), 32'hC0);
            sb.delete();
            clearAcc();
        end else begin
            if (sb.size() > 0 && cyc > sb[0].acc) begin
                rel = cyc - sb[0].acc;
                if (!busy_o && done_o == 2'b00) busy_low++;
                if (!lcd_cs_n) begin
                    cs_low++;
                    if (cs_fall < 0) cs_fall = rel;
                end
                if (!lcd_res) begin
                    res_low++;
                    if (res_first < 0) res_first = rel;
                    res_last = rel;
                end
                if (lcd_sclk && !prev_sclk) begin
                    rises++;
                    cap = {cap[7:0], lcd_mosi};
                    if (lcd_dc !== sb[0].dc) dc_bad++;
                end
            end
            if (done_o != 2'b00) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'(done_o), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    checkOutput("done_code", 32'(done_o), 32'(cur.kind));
                    checkOutput("done_cycle", 32'(cyc - cur.acc), 32'(cur.lat));
                    checkOutput("busy_in_done", 32'(busy_o), 32'd0);
                    checkOutput("busy_window", 32'(busy_low), 32'd0);
                    if (cur.kind == 2) begin
                        checkOutput("sclk_rises", 32'(rises), 32'(NB));
                        checkOutput("mosi_bits", 32'(cap), 32'(cur.bits));
                        checkOutput("dc_at_rise", 32'(dc_bad), 32'd0);
                        checkOutput("cs_fall_cycle", 32'(cs_fall), 32'd1);
                        checkOutput("cs_low_cycles", 32'(cs_low), 32'(cur.lat - 1));
                        checkOutput("cs_high_at_done", 32'(lcd_cs_n), 32'd1);
                        checkOutput("res_during_write", 32'(res_low), 32'd0);
                    end else begin
                        checkOutput("res_first_low", 32'(res_first), 32'd1);
                        checkOutput("res_last_low", 32'(res_last), 32'(L));
                        checkOutput("res_low_cycles", 32'(res_low), 32'(L));
                        checkOutput("cs_during_reset", 32'(cs_low), 32'd0);
                        checkOutput("sclk_during_reset", 32'(rises), 32'd0);
                    end
                    clearAcc();
                end
            end else if (sb.size() > 0 && (cyc - sb[0].acc) > sb[0].lat + 4) begin
                checkOutput("done_timeout", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
                cur = sb.pop_front();
                clearAcc();
            end
        end
        prev_sclk = lcd_sclk;
    end

    task automatic applyStimulus(input logic [1:0] en, input logic [8:0] d);
        @(posedge clk);
        #1;
        en_i   = en;
        data_i = d;
        sb.push_back(model(en, d, cyc));
        @(posedge clk);
        #1;
        en_i = 2'b00;
    endtask

    task automatic ignoredPulse(input int gap);
        repeat (gap) @(posedge clk);
        #1;
        en_i   = 2'($urandom_range(1, 3));
        data_i = 9'($urandom);
        @(posedge clk);
        #1;
        en_i = 2'b00;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 500 && sb.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() > 0) begin
            $display("[TB] FAIL wait_idle: %0d requests still pending, expected 0", sb.size());
            $fatal(1, "[TB] scoreboard did not drain");
        end
    endtask

    initial begin
        clearAcc();
        prev_sclk = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(2'b01, 9'h000);
        waitIdle();
        applyStimulus(2'b10, 9'h036);
        waitIdle();

        // Pulse at cycle 20 must be ignored; next write lands at cycle 36.
        applyStimulus(2'b10, 9'h1F8);
        repeat (19) @(posedge clk);
        #1;
        en_i   = 2'b10;
        data_i = 9'h0AA;
        @(posedge clk);
        #1 en_i = 2'b00;
        waitIdle();
        applyStimulus(2'b10, 9'h0F0);
        waitIdle();

        applyStimulus(2'b11, 9'h055);
        waitIdle();

        applyStimulus(2'b10, 9'h0C5);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (45) @(negedge clk);
        applyStimulus(2'b10, 9'h0A5);
        waitIdle();

        applyStimulus(2'b10, 9'h12C);
        waitIdle();

        for (int k = 0; k < 12; k++) begin
            int         r;
            logic [1:0] en;
            r  = $urandom_range(0, 5);
            en = (r == 0) ? 2'b01 : (r == 1) ? 2'b11 : 2'b10;
            applyStimulus(en, 9'($urandom));
            if ($urandom_range(0, 1) == 1) ignoredPulse($urandom_range(2, 12));
            waitIdle();
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
